// File: rtl/lcd_bus_rx_pkg.sv
// rtl/lcd_bus_rx_pkg.sv - ILI9341 subset command codes, FSM states and helpers
package lcd_bus_rx_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;
    localparam logic [7:0] CMD_TEOFF = 8'h34;
    localparam logic [7:0] CMD_TEON  = 8'h35;

    localparam int LCD_W_DEF = 240;
    localparam int LCD_H_DEF = 320;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_PASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_SKIP  = 3'd4
    } state_t;

    function automatic logic [8:0] join9(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[0], lo};
    endfunction

endpackage

// File: rtl/lcd_wr_sync.sv
// rtl/lcd_wr_sync.sv - 2-flop synchronizer for WR/RS/data with WR rising-edge strobe
module lcd_wr_sync (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_lcd_wr,
    input  logic       i_lcd_rs,
    input  logic [7:0] i_lcd_data,
    output logic       o_strobe,
    output logic       o_rs,
    output logic [7:0] o_data
);

    logic       r_wr_s1, r_wr_s2, r_wr_s3;
    logic       r_rs_s1, r_rs_s2;
    logic [7:0] r_data_s1, r_data_s2;
    logic       r_strobe;
    logic       r_rs_q;
    logic [7:0] r_data_q;
    logic       w_edge;

    assign w_edge = r_wr_s2 && !r_wr_s3;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_s1   <= 1'b0;
            r_wr_s2   <= 1'b0;
            r_wr_s3   <= 1'b0;
            r_rs_s1   <= 1'b0;
            r_rs_s2   <= 1'b0;
            r_data_s1 <= 8'h00;
            r_data_s2 <= 8'h00;
            r_strobe  <= 1'b0;
            r_rs_q    <= 1'b0;
            r_data_q  <= 8'h00;
        end else begin
            r_wr_s1   <= i_lcd_wr;
            r_wr_s2   <= r_wr_s1;
            r_wr_s3   <= r_wr_s2;
            r_rs_s1   <= i_lcd_rs;
            r_rs_s2   <= r_rs_s1;
            r_data_s1 <= i_lcd_data;
            r_data_s2 <= r_data_s1;
            r_strobe  <= w_edge;
            // RS/data sampled from the same stage that saw WR rise
            if (w_edge) begin
                r_rs_q   <= r_rs_s2;
                r_data_q <= r_data_s2;
            end
        end
    end

    assign o_strobe = r_strobe;
    assign o_rs     = r_rs_q;
    assign o_data   = r_data_q;

endmodule

// File: rtl/lcd_bus_rx.sv
// rtl/lcd_bus_rx.sv - 8080 LCD write-bus receiver (ILI9341 subset); tearing pulse built with LCD_BUS_RX_FMARK_EN
module lcd_bus_rx
    import lcd_bus_rx_pkg::*;
#(
    parameter int          LCD_W        = LCD_W_DEF,
    parameter int          LCD_H        = LCD_H_DEF,
    parameter logic [15:0] FMARK_PERIOD = 16'd800,
    parameter logic [15:0] FMARK_WIDTH  = 16'd8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_lcd_data,
    input  logic        i_lcd_rs,
    input  logic        i_lcd_wr,
    output logic        o_lcd_fmark,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_pix_valid,
    output logic [8:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [15:0] o_pix_rgb
);

    localparam logic [8:0] X_MAX = 9'(LCD_W - 1);
    localparam logic [8:0] Y_MAX = 9'(LCD_H - 1);

    logic       w_strobe;
    logic       w_rs;
    logic [7:0] w_data;

    lcd_wr_sync u_sync (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_lcd_wr   (i_lcd_wr),
        .i_lcd_rs   (i_lcd_rs),
        .i_lcd_data (i_lcd_data),
        .o_strobe   (w_strobe),
        .o_rs       (w_rs),
        .o_data     (w_data)
    );

    state_t      r_state;
    logic [8:0]  r_sc, r_ec, r_sp, r_ep;
    logic [8:0]  r_x, r_y;
    logic [2:0]  r_idx;
    logic [7:0]  r_hi;
    logic        r_half;
    logic [7:0]  r_pix_hi;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd;
    logic        r_pix_valid;
    logic [8:0]  r_pix_x, r_pix_y;
    logic [15:0] r_pix_rgb;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_sc        <= 9'd0;
            r_ec        <= X_MAX;
            r_sp        <= 9'd0;
            r_ep        <= Y_MAX;
            r_x         <= 9'd0;
            r_y         <= 9'd0;
            r_idx       <= 3'd0;
            r_hi        <= 8'h00;
            r_half      <= 1'b0;
            r_pix_hi    <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_cmd       <= 8'h00;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 9'd0;
            r_pix_y     <= 9'd0;
            r_pix_rgb   <= 16'h0000;
        end else begin
            r_cmd_valid <= 1'b0;
            r_pix_valid <= 1'b0;
            if (w_strobe && !w_rs) begin
                r_cmd_valid <= 1'b1;
                r_cmd       <= w_data;
                r_idx       <= 3'd0;
                r_half      <= 1'b0;
                case (w_data)
                    CMD_CASET: r_state <= ST_CASET;
                    CMD_PASET: r_state <= ST_PASET;
                    CMD_RAMWR: begin
                        r_state <= ST_RAMWR;
                        r_x     <= r_sc;
                        r_y     <= r_sp;
                    end
                    default:   r_state <= ST_SKIP;
                endcase
            end else if (w_strobe) begin
                case (r_state)
                    ST_CASET, ST_PASET: begin
                        if (r_idx < 3'd4)
                            r_idx <= r_idx + 3'd1;
                        // Each 9-bit value is committed only once its low byte lands
                        case (r_idx)
                            3'd0, 3'd2: r_hi <= w_data;
                            3'd1: begin
                                if (r_state == ST_CASET) r_sc <= join9(r_hi, w_data);
                                else                     r_sp <= join9(r_hi, w_data);
                            end
                            3'd3: begin
                                if (r_state == ST_CASET) r_ec <= join9(r_hi, w_data);
                                else                     r_ep <= join9(r_hi, w_data);
                            end
                            default: ;
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!r_half) begin
                            r_pix_hi <= w_data;
                            r_half   <= 1'b1;
                        end else begin
                            r_half      <= 1'b0;
                            r_pix_valid <= 1'b1;
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_pix_rgb   <= {r_pix_hi, w_data};
                            if (r_x >= r_ec) begin
                                r_x <= r_sc;
                                r_y <= (r_y >= r_ep) ? r_sp : r_y + 9'd1;
                            end else begin
                                r_x <= r_x + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd       = r_cmd;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_x     = r_pix_x;
    assign o_pix_y     = r_pix_y;
    assign o_pix_rgb   = r_pix_rgb;

`ifdef LCD_BUS_RX_FMARK_EN
    logic        r_te_on;
    logic [15:0] r_te_cnt;
    logic        r_fmark;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_te_on  <= 1'b0;
            r_te_cnt <= 16'd0;
            r_fmark  <= 1'b0;
        end else begin
            if (w_strobe && !w_rs && w_data == CMD_TEON)  r_te_on <= 1'b1;
            if (w_strobe && !w_rs && w_data == CMD_TEOFF) r_te_on <= 1'b0;
            r_te_cnt <= (r_te_cnt >= FMARK_PERIOD - 16'd1) ? 16'd0 : r_te_cnt + 16'd1;
            r_fmark  <= r_te_on && (r_te_cnt < FMARK_WIDTH);
        end
    end

    assign o_lcd_fmark = r_fmark;
`else
    // No tearing generator; parameters only kept so both builds share one interface
    assign o_lcd_fmark = 1'b0 & |{FMARK_PERIOD, FMARK_WIDTH};
`endif

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb/tb_lcd_bus_rx.sv - table-driven bench for lcd_bus_rx
module tb_lcd_bus_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  lcd_data = 8'h00;
    logic        lcd_rs = 1'b0;
    logic        lcd_wr = 1'b0;
    logic        fmark;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        pix_valid;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_rgb;

    always #5 clk = ~clk;

    lcd_bus_rx #(
        .LCD_W        (240),
        .LCD_H        (320),
        .FMARK_PERIOD (16'd20),
        .FMARK_WIDTH  (16'd3)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_lcd_data  (lcd_data),
        .i_lcd_rs    (lcd_rs),
        .i_lcd_wr    (lcd_wr),
        .o_lcd_fmark (fmark),
        .o_cmd_valid (cmd_valid),
        .o_cmd       (cmd),
        .o_pix_valid (pix_valid),
        .o_pix_x     (pix_x),
        .o_pix_y     (pix_y),
        .o_pix_rgb   (pix_rgb)
    );

    int          cmd_total = 0;
    int          pix_total = 0;
    logic [7:0]  last_cmd;
    logic [8:0]  last_x, last_y;
    logic [15:0] last_rgb;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_total <= cmd_total + 1;
            last_cmd  <= cmd;
        end
        if (pix_valid) begin
            pix_total <= pix_total + 1;
            last_x    <= pix_x;
            last_y    <= pix_y;
            last_rgb  <= pix_rgb;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rs;
        logic [7:0]  d;
        int          ncmd;
        logic [7:0]  cmd;
        int          npix;
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] rgb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, input logic [7:0] d, input int ncmd, input logic [7:0] c,
                       input int npix, input logic [8:0] x, input logic [8:0] y, input logic [15:0] rgb);
        vec_t v;
        v.rs = rs; v.d = d; v.ncmd = ncmd; v.cmd = c;
        v.npix = npix; v.x = x; v.y = y; v.rgb = rgb;
        vecs.push_back(v);
    endtask

    task automatic c_(input logic [7:0] d);
        add(1'b0, d, 1, d, 0, 9'd0, 9'd0, 16'h0);
    endtask

    task automatic p_(input logic [7:0] d);
        add(1'b1, d, 0, 8'h00, 0, 9'd0, 9'd0, 16'h0);
    endtask

    task automatic px(input logic [7:0] d, input int x, input int y, input logic [15:0] rgb);
        add(1'b1, d, 0, 8'h00, 1, 9'(x), 9'(y), rgb);
    endtask

    task automatic wr_byte(input logic rs, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_rs   = rs;
        lcd_data = d;
        repeat (3) @(posedge clk);
        #1 lcd_wr = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_wr = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        chk({tag, "_cmd"},       {24'd0, cmd},       32'd0);
        chk({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, "_pix_x"},     {23'd0, pix_x},     32'd0);
        chk({tag, "_pix_y"},     {23'd0, pix_y},     32'd0);
        chk({tag, "_pix_rgb"},   {16'd0, pix_rgb},   32'd0);
        chk({tag, "_fmark"},     {31'd0, fmark},     32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c0, p0;
        string n;
        c0 = cmd_total;
        p0 = pix_total;
        wr_byte(v.rs, v.d);
        @(negedge clk);
        n = $sformatf("v%0d", idx);
        chk({n, "_ncmd"}, 32'(cmd_total - c0), 32'(v.ncmd));
        chk({n, "_npix"}, 32'(pix_total - p0), 32'(v.npix));
        if (v.ncmd == 1)
            chk({n, "_cmd"}, {24'd0, last_cmd}, {24'd0, v.cmd});
        if (v.npix == 1) begin
            chk({n, "_x"},   {23'd0, last_x},   {23'd0, v.x});
            chk({n, "_y"},   {23'd0, last_y},   {23'd0, v.y});
            chk({n, "_rgb"}, {16'd0, last_rgb}, {16'd0, v.rgb});
        end
    endtask

    task automatic count_fmark(output int highs);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fmark) highs++;
        end
    endtask

    initial begin
        int hi_cnt;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        chk_zero("idle");

        // basic RAMWR in the default window
        c_(8'h2C);
        p_(8'hF8); px(8'h00, 0, 0, 16'hF800);
        p_(8'h07); px(8'hE0, 1, 0, 16'h07E0);
        // 2x2 window with row and column wrap
        c_(8'h2A); p_(8'h00); p_(8'h0A); p_(8'h00); p_(8'h0B);
        c_(8'h2B); p_(8'h00); p_(8'h05); p_(8'h00); p_(8'h06);
        c_(8'h2C);
        p_(8'h11); px(8'h11, 10, 5, 16'h1111);
        p_(8'h22); px(8'h22, 11, 5, 16'h2222);
        p_(8'h33); px(8'h33, 10, 6, 16'h3333);
        p_(8'h44); px(8'h44, 11, 6, 16'h4444);
        p_(8'h55); px(8'h55, 10, 5, 16'h5555);
        // half pixel dropped by a command, then RAMWR restarts at SC,SP
        c_(8'h2C); p_(8'hAA); c_(8'h00);
        c_(8'h2C); p_(8'h12); px(8'h34, 10, 5, 16'h1234);
        // unknown command swallows parameters, window unchanged
        c_(8'hB1); p_(8'h01); p_(8'h02); p_(8'h03);
        c_(8'h2C); p_(8'h56); px(8'h78, 10, 5, 16'h5678);
        // CASET with only a start value; PASET with surplus bytes ignored
        c_(8'h2A); p_(8'h00); p_(8'h03); p_(8'h01);
        c_(8'h2B); p_(8'h00); p_(8'h07); p_(8'h00); p_(8'h07); p_(8'h01); p_(8'h01);
        c_(8'h2C);
        p_(8'h9A); px(8'hBC, 3, 7, 16'h9ABC);
        p_(8'hDE); px(8'hF0, 4, 7, 16'hDEF0);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // reset in the middle of CASET after two parameters
        wr_byte(1'b0, 8'h2A);
        wr_byte(1'b1, 8'h00);
        wr_byte(1'b1, 8'h50);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        vecs.delete();
        c_(8'h2C);
        p_(8'hAB); px(8'hCD, 0, 0, 16'hABCD);
        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], 100 + i);

        // tearing effect on, then off
        wr_byte(1'b0, 8'h35);
        count_fmark(hi_cnt);
`ifdef LCD_BUS_RX_FMARK_EN
        chk("fmark_on_highs", 32'(hi_cnt), 32'd6);
`else
        chk("fmark_on_highs", 32'(hi_cnt), 32'd0);
`endif
        wr_byte(1'b0, 8'h34);
        count_fmark(hi_cnt);
        chk("fmark_off_highs", 32'(hi_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
